rot_ctl: RTL and testbench
==========================

ROT_CTL -- requirements
Module: rot_ctl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 16, consecutive stable samples before a switch contact change is accepted.
REQ-002 Parameter SETTLE_CYCLES, 4, wait after a position change before fetching.
REQ-003 Parameter REFRESH_CYCLES, 1024, interval between display re-fetches while the CPU is stopped.
REQ-004 Parameter TIMEOUT_CYCLES, 64, maximum wait for fetch_ack.
REQ-005 Port clk_sys, input, 1, the only clock; all state on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port rot_up, input, 1, raw panel step-up contact, asynchronous.
REQ-008 Port rot_dn, input, 1, raw panel step-down contact, asynchronous.
REQ-009 Port cpu_stop, input, 1, CPU halted; fetches permitted only while high.
REQ-010 Port fetch_ack, input, 1, bus_data valid for the selected register.
REQ-011 Port bus_data, input, 16, register value from the internal bus.
REQ-012 Port rot_pos, output, 4, current switch position, 0..14.
REQ-013 Port rot_bus, output, 11, register bus select decoded from rot_pos.
REQ-014 Port fetch_req, output, 1, request to drive the selected register onto the bus.
REQ-015 Port disp_data, output, 16, latched display value.
REQ-016 Port disp_valid, output, 1, disp_data matches current rot_pos.
REQ-017 Port fetch_err, output, 1, last fetch timed out; sticky.

Function
REQ-018 rot_up/rot_dn SHALL pass a 2-flop synchronizer; a step is the rising edge of the resulting (debounced) level.
REQ-019 A step SHALL update rot_pos on the following clock edge: up 0..13 -> +1, 14 -> 0; down 1..14 -> -1, 0 -> 14; value 15 never produced.
REQ-020 Up and down steps in the same cycle SHALL both be ignored.
REQ-021 rot_bus SHALL be combinational from rot_pos: positions 0..7 -> bit10 set with position in bits 9:7; 8..14 -> one-hot bit 6 (IC), 5 (AC), 4 (AR), 3 (IR), 2 (SR), 1 (RZ), 0 (KB).
REQ-022 FSM states IDLE, SETTLE, REQ, HOLD.
REQ-023 A step in any state SHALL force SETTLE next cycle, clear disp_valid, deassert fetch_req, restart the settle counter, clear fetch_err.
REQ-024 SETTLE: after SETTLE_CYCLES cycles -> REQ if cpu_stop, else IDLE.
REQ-025 IDLE: cpu_stop high -> REQ next cycle.
REQ-026 REQ: fetch_req high; on fetch_ack, capture bus_data into disp_data, set disp_valid, clear fetch_err, go HOLD; fetch_req low the next cycle.
REQ-027 REQ: TIMEOUT_CYCLES cycles without fetch_ack -> set fetch_err, clear disp_valid, go HOLD.
REQ-028 REQ/HOLD: cpu_stop low -> IDLE next cycle, fetch_req low, disp_data and disp_valid retained.
REQ-029 HOLD: after REFRESH_CYCLES cycles -> REQ; disp_valid stays high during refresh fetch until replaced or timed out.
REQ-030 fetch_ack outside REQ SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately set rot_pos=0, rot_bus=11'b10000000000, fetch_req=0, disp_data=0, disp_valid=0, fetch_err=0, state IDLE, all counters and synchronizers 0.
REQ-032 Reset during REQ SHALL drop fetch_req asynchronously with no capture.

Configuration
REQ-033 With ROT_DEBOUNCE_EN defined, each contact SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-034 Without ROT_DEBOUNCE_EN, synchronizer outputs SHALL be used directly and DEBOUNCE_CYCLES is unused.

Structure
REQ-035 Package rot_pkg SHALL hold the 15 bus-select localparams, position width, data width and FSM state enum.
REQ-036 Decode SHALL live in sub-module rot_bus_dec (4-bit in, 11-bit out); rot_ctl instantiates it once.

Verification
REQ-037 Reset release, cpu_stop=1, ack 2 cycles after req with bus_data=16'h1234 -> disp_data=16'h1234, disp_valid=1, rot_bus=11'b10000000000.
REQ-038 Eight up steps from 0 -> rot_pos=8, rot_bus=11'b00001000000; further 6 ups -> 14, next up -> 0; down from 0 -> 14.
REQ-039 Step while fetch_req high -> fetch_req low next cycle, disp_valid=0, new fetch after SETTLE_CYCLES.
REQ-040 No ack for 64 cycles -> fetch_err=1, disp_valid=0; next successful ack clears fetch_err.
REQ-041 ROT_DEBOUNCE_EN: 10-cycle glitch on rot_up -> no step; 20-cycle pulse -> exactly one step.
REQ-042 Simultaneous up and down pulses -> rot_pos unchanged, FSM state unchanged.

Source files
------------

// File: rtl/rot_pkg.sv
// rot_pkg -- shared definitions for the rotary register-select controller.
//   Holds the position/data widths, the fifteen register bus-select codes
//   and the fetch FSM state type used by rot_ctl and rot_bus_dec.
package rot_pkg;

   localparam int ROT_POS_W  = 4;
   localparam int ROT_DATA_W = 16;
   localparam int ROT_BUS_W  = 11;

   localparam logic [ROT_POS_W-1:0] POS_LAST = 4'd14;

   // Positions 0..7: bit 10 set, position number in bits 9:7.
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_P0 = 11'b100_0000_0000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_P1 = 11'b100_1000_0000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_P2 = 11'b101_0000_0000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_P3 = 11'b101_1000_0000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_P4 = 11'b110_0000_0000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_P5 = 11'b110_1000_0000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_P6 = 11'b111_0000_0000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_P7 = 11'b111_1000_0000;
   // Positions 8..14: one-hot named registers.
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_IC = 11'b000_0100_0000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_AC = 11'b000_0010_0000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_AR = 11'b000_0001_0000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_IR = 11'b000_0000_1000;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_SR = 11'b000_0000_0100;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_RZ = 11'b000_0000_0010;
   localparam logic [ROT_BUS_W-1:0] BUS_SEL_KB = 11'b000_0000_0001;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_REQ    = 2'd2,
      ST_HOLD   = 2'd3
   } rot_state_e;

endpackage

// File: rtl/rot_bus_dec.sv
// rot_bus_dec -- combinational decode of switch position to register bus select.
//   pos_i [3:0]  : switch position 0..14
//   bus_o [10:0] : bus select code (all zero for the unused code 15)
module rot_bus_dec
   import rot_pkg::*;
(
   input  logic [ROT_POS_W-1:0] pos_i,
   output logic [ROT_BUS_W-1:0] bus_o
);

   // Position to bus-select lookup.
   always_comb begin
      bus_o = {ROT_BUS_W{1'b0}};
      case (pos_i)
         4'd0:    bus_o = BUS_SEL_P0;
         4'd1:    bus_o = BUS_SEL_P1;
         4'd2:    bus_o = BUS_SEL_P2;
         4'd3:    bus_o = BUS_SEL_P3;
         4'd4:    bus_o = BUS_SEL_P4;
         4'd5:    bus_o = BUS_SEL_P5;
         4'd6:    bus_o = BUS_SEL_P6;
         4'd7:    bus_o = BUS_SEL_P7;
         4'd8:    bus_o = BUS_SEL_IC;
         4'd9:    bus_o = BUS_SEL_AC;
         4'd10:   bus_o = BUS_SEL_AR;
         4'd11:   bus_o = BUS_SEL_IR;
         4'd12:   bus_o = BUS_SEL_SR;
         4'd13:   bus_o = BUS_SEL_RZ;
         4'd14:   bus_o = BUS_SEL_KB;
         default: bus_o = {ROT_BUS_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/rot_ctl.sv
// rot_ctl -- front-panel rotary register selector with display fetch.
//   Synchronizes (and optionally debounces) the step-up/step-down contacts,
//   tracks the 15-position switch, and fetches the selected register over the
//   internal bus while the CPU is stopped, refreshing it periodically.
//   Build option: define ROT_DEBOUNCE_EN to require DEBOUNCE_CYCLES
//   consecutive equal synchronized samples before a contact change is taken.
// Ports:
//   clk_sys, rst_n (async active-low)        -- clock / reset
//   rot_up, rot_dn                            -- raw contacts (asynchronous)
//   cpu_stop, fetch_ack, bus_data[15:0]       -- CPU status and bus response
//   rot_pos[3:0], rot_bus[10:0]               -- position and decoded select
//   fetch_req, disp_data[15:0], disp_valid, fetch_err -- fetch/display status
module rot_ctl
   import rot_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned SETTLE_CYCLES   = 4,
   parameter int unsigned REFRESH_CYCLES  = 1024,
   parameter int unsigned TIMEOUT_CYCLES  = 64
)(
   input  logic                  clk_sys,
   input  logic                  rst_n,
   input  logic                  rot_up,
   input  logic                  rot_dn,
   input  logic                  cpu_stop,
   input  logic                  fetch_ack,
   input  logic [ROT_DATA_W-1:0] bus_data,
   output logic [ROT_POS_W-1:0]  rot_pos,
   output logic [ROT_BUS_W-1:0]  rot_bus,
   output logic                  fetch_req,
   output logic [ROT_DATA_W-1:0] disp_data,
   output logic                  disp_valid,
   output logic                  fetch_err
);

   // One counter width serves every timer in the block.
   localparam int unsigned MAX_A   = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned MAX_B   = (REFRESH_CYCLES > DEBOUNCE_CYCLES) ? REFRESH_CYCLES : DEBOUNCE_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int          CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   // Bit 0 = up contact, bit 1 = down contact throughout.
   logic [1:0] sync1_q, sync2_q, prev_q, lvl_s, rise_s;
   logic       step_up_s, step_dn_s, step_s;

   logic [ROT_POS_W-1:0]  pos_q, pos_d;
   rot_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ROT_DATA_W-1:0] disp_data_q, disp_data_d;
   logic                  disp_valid_q, disp_valid_d;
   logic                  fetch_err_q, fetch_err_d;
   logic                  fetch_req_q;

   // Two-flop synchronizer plus previous-level register for edge detection.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
         prev_q  <= 2'b00;
      end else begin
         sync1_q <= {rot_dn, rot_up};
         sync2_q <= sync1_q;
         prev_q  <= lvl_s;
      end
   end

`ifdef ROT_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       stable_q;
   logic [CNT_W-1:0] deb_cnt_q [2];

   // Debounce: a contact level is taken only after DEBOUNCE_CYCLES samples in a row differ from it.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         stable_q     <= 2'b00;
         deb_cnt_q[0] <= CNT_ZERO;
         deb_cnt_q[1] <= CNT_ZERO;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
               deb_cnt_q[i] <= CNT_ZERO;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
               stable_q[i]  <= sync2_q[i];
               deb_cnt_q[i] <= CNT_ZERO;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   assign lvl_s = stable_q;
`else
   assign lvl_s = sync2_q;
`endif

   // Opposing steps in the same cycle cancel each other.
   assign rise_s    = lvl_s & ~prev_q;
   assign step_up_s = rise_s[0] & ~rise_s[1];
   assign step_dn_s = rise_s[1] & ~rise_s[0];
   assign step_s    = step_up_s | step_dn_s;

   // Next position, wrapping 14 <-> 0 so code 15 is never reached.
   always_comb begin
      pos_d = pos_q;
      if (step_up_s) begin
         pos_d = (pos_q == POS_LAST) ? 4'd0 : pos_q + 4'd1;
      end else if (step_dn_s) begin
         pos_d = (pos_q == 4'd0) ? POS_LAST : pos_q - 4'd1;
      end else begin
         pos_d = pos_q;
      end
   end

   // Fetch FSM next-state; a step overrides whatever the FSM was doing.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      disp_data_d  = disp_data_q;
      disp_valid_d = disp_valid_q;
      fetch_err_d  = fetch_err_q;
      if (step_s) begin
         state_d      = ST_SETTLE;
         cnt_d        = CNT_ZERO;
         disp_valid_d = 1'b0;
         fetch_err_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cpu_stop) begin
                  state_d = ST_REQ;
                  cnt_d   = CNT_ZERO;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d = cpu_stop ? ST_REQ : ST_IDLE;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_REQ: begin
               if (!cpu_stop) begin
                  state_d = ST_IDLE;
                  cnt_d   = CNT_ZERO;
               end else if (fetch_ack) begin
                  state_d      = ST_HOLD;
                  cnt_d        = CNT_ZERO;
                  disp_data_d  = bus_data;
                  disp_valid_d = 1'b1;
                  fetch_err_d  = 1'b0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d      = ST_HOLD;
                  cnt_d        = CNT_ZERO;
                  disp_valid_d = 1'b0;
                  fetch_err_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_HOLD: begin
               if (!cpu_stop) begin
                  state_d = ST_IDLE;
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q == REFRESH_LAST) begin
                  state_d = ST_REQ;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   // State, counters and registered outputs; fetch_req tracks the REQ state.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         pos_q        <= 4'd0;
         state_q      <= ST_IDLE;
         cnt_q        <= CNT_ZERO;
         disp_data_q  <= 16'h0000;
         disp_valid_q <= 1'b0;
         fetch_err_q  <= 1'b0;
         fetch_req_q  <= 1'b0;
      end else begin
         pos_q        <= pos_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         disp_data_q  <= disp_data_d;
         disp_valid_q <= disp_valid_d;
         fetch_err_q  <= fetch_err_d;
         fetch_req_q  <= (state_d == ST_REQ);
      end
   end

   rot_bus_dec u_bus_dec (
      .pos_i (pos_q),
      .bus_o (rot_bus)
   );

   assign rot_pos    = pos_q;
   assign fetch_req  = fetch_req_q;
   assign disp_data  = disp_data_q;
   assign disp_valid = disp_valid_q;
   assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_rot_ctl.sv
// tb_rot_ctl -- self-checking bench for rot_ctl (default parameters).
//   Directed and randomized steps checked against a position/display model;
//   also exercises the ROT_DEBOUNCE_EN glitch rejection when that macro is set.
module tb_rot_ctl;

   localparam int SETTLE = 4;
   localparam int TMO    = 64;
   localparam int REFR   = 1024;
   localparam int DEB    = 16;
`ifdef ROT_DEBOUNCE_EN
   localparam int PW    = DEB + 4;
   localparam int QUIET = DEB + 40;
   localparam int REL   = DEB + 8;
`else
   localparam int PW    = 3;
   localparam int QUIET = 30;
   localparam int REL   = 10;
`endif

   logic        clk_sys, rst_n, rot_up, rot_dn, cpu_stop, fetch_ack;
   logic [15:0] bus_data;
   logic [3:0]  rot_pos;
   logic [10:0] rot_bus;
   logic        fetch_req, disp_valid, fetch_err;
   logic [15:0] disp_data;

   // bus responder controls
   logic        ack_en;
   int          ack_delay;
   logic [15:0] resp_data;

   // reference model
   int          pos_m;
   logic [15:0] disp_m;

   int total = 0;
   int bad   = 0;

   rot_ctl dut (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .rot_up     (rot_up),
      .rot_dn     (rot_dn),
      .cpu_stop   (cpu_stop),
      .fetch_ack  (fetch_ack),
      .bus_data   (bus_data),
      .rot_pos    (rot_pos),
      .rot_bus    (rot_bus),
      .fetch_req  (fetch_req),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .fetch_err  (fetch_err)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Expected bus select from the position rules.
   function automatic logic [10:0] exp_bus(input int p);
      if (p < 8) return 11'(1024 + p * 128);
      else       return 11'(1 << (14 - p));
   endfunction

   task automatic wait_req(input logic lvl, input int maxc, input string tag);
      int n;
      n = 0;
      while (fetch_req !== lvl && n < maxc) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(fetch_req), 32'(lvl));
   endtask

   task automatic do_step(input bit up);
      if (up) rot_up = 1'b1; else rot_dn = 1'b1;
      tick(PW);
      rot_up = 1'b0;
      rot_dn = 1'b0;
      tick(QUIET);
      pos_m = up ? (pos_m + 1) % 15 : (pos_m + 14) % 15;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_pos"},   32'(rot_pos),    32'(pos_m));
      chk({tag, "_bus"},   32'(rot_bus),    32'(exp_bus(pos_m)));
      chk({tag, "_data"},  32'(disp_data),  32'(disp_m));
      chk({tag, "_valid"}, 32'(disp_valid), 32'd1);
      chk({tag, "_err"},   32'(fetch_err),  32'd0);
   endtask

   // Bus responder: acks ack_delay cycles after fetch_req is seen high.
   initial begin
      int age;
      age       = 0;
      fetch_ack = 1'b0;
      bus_data  = 16'h0000;
      forever begin
         @(posedge clk_sys);
         #1;
         fetch_ack = 1'b0;
         if (fetch_req && ack_en) begin
            if (age >= ack_delay) begin
               fetch_ack = 1'b1;
               bus_data  = resp_data;
               age       = 0;
            end else begin
               age++;
            end
         end else begin
            age = 0;
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0; rot_up = 1'b0; rot_dn = 1'b0; cpu_stop = 1'b0;
      ack_en = 1'b0; ack_delay = 2; resp_data = 16'h0000;
      pos_m = 0; disp_m = 16'h0000;
      tick(3);
      chk("rst_pos",   32'(rot_pos),    32'd0);
      chk("rst_bus",   32'(rot_bus),    32'h400);
      chk("rst_req",   32'(fetch_req),  32'd0);
      chk("rst_data",  32'(disp_data),  32'd0);
      chk("rst_valid", 32'(disp_valid), 32'd0);
      chk("rst_err",   32'(fetch_err),  32'd0);

      // first fetch after reset
      cpu_stop = 1'b1; ack_en = 1'b1; resp_data = 16'h1234; ack_delay = 2;
      rst_n = 1'b1;
      wait_req(1'b1, 10, "first_req");
      wait_req(1'b0, 10, "first_req_drop");
      tick(2);
      disp_m = 16'h1234;
      check_all("first");

      // eight ups to position 8
      for (int i = 0; i < 8; i++) begin
         resp_data = 16'($urandom);
         disp_m    = resp_data;
         do_step(1'b1);
      end
      check_all("up8");
      chk("pos8_const", 32'(rot_pos), 32'd8);
      chk("bus8_const", 32'(rot_bus), 32'h040);
      for (int i = 0; i < 6; i++) do_step(1'b1);
      chk("pos14", 32'(rot_pos), 32'd14);
      do_step(1'b1);
      chk("wrap_up", 32'(rot_pos), 32'd0);
      do_step(1'b0);
      chk("wrap_dn", 32'(rot_pos), 32'd14);
      check_all("wrap");

      // randomized steps
      for (int i = 0; i < 12; i++) begin
         resp_data = 16'($urandom);
         disp_m    = resp_data;
         ack_delay = int'($urandom_range(0, 5));
         do_step(1'($urandom_range(0, 1)));
         check_all("rnd");
      end

      // step while fetch_req is high, then timeout
      ack_en = 1'b0;
      rot_up = 1'b1; tick(PW); rot_up = 1'b0; tick(REL);
      pos_m = (pos_m + 1) % 15;
      chk("req_pending", 32'(fetch_req), 32'd1);
      rot_up = 1'b1;
      wait_req(1'b0, PW + 4, "req_drop_on_step");
      pos_m = (pos_m + 1) % 15;
      chk("step_valid", 32'(disp_valid), 32'd0);
      chk("step_pos",   32'(rot_pos),    32'(pos_m));
      n = 0;
      while (!fetch_req && n < 20) begin tick(1); n++; end
      chk("settle_gap", 32'(n), 32'(SETTLE));
      rot_up = 1'b0;
      n = 0;
      while (fetch_req && n < 200) begin tick(1); n++; end
      chk("timeout_len",   32'(n),          32'(TMO));
      chk("timeout_err",   32'(fetch_err),  32'd1);
      chk("timeout_valid", 32'(disp_valid), 32'd0);

      // refresh fetch after timeout clears the error
      ack_en = 1'b1; ack_delay = 1; resp_data = 16'($urandom); disp_m = resp_data;
      wait_req(1'b1, REFR + 10, "refresh_req");
      wait_req(1'b0, 20, "refresh_done");
      tick(1);
      check_all("recover");

      // cpu running: keep display, no fetches
      cpu_stop = 1'b0;
      tick(3);
      chk("run_req",   32'(fetch_req),  32'd0);
      chk("run_data",  32'(disp_data),  32'(disp_m));
      chk("run_valid", 32'(disp_valid), 32'd1);
      do_step(1'b0);
      chk("run_step_pos",   32'(rot_pos),    32'(pos_m));
      chk("run_step_valid", 32'(disp_valid), 32'd0);
      chk("run_step_req",   32'(fetch_req),  32'd0);
      resp_data = 16'($urandom); disp_m = resp_data;
      cpu_stop = 1'b1;
      tick(15);
      check_all("restop");

      // simultaneous up and down cancel
      rot_up = 1'b1; rot_dn = 1'b1;
      tick(PW);
      rot_up = 1'b0; rot_dn = 1'b0;
      tick(QUIET);
      check_all("both");
      chk("both_req", 32'(fetch_req), 32'd0);

`ifdef ROT_DEBOUNCE_EN
      rot_up = 1'b1; tick(10); rot_up = 1'b0; tick(40);
      check_all("glitch");
      rot_up = 1'b1; tick(20); rot_up = 1'b0; tick(40);
      pos_m = (pos_m + 1) % 15;
      chk("pulse20_pos", 32'(rot_pos), 32'(pos_m));
`endif

      // reset while a fetch is pending
      ack_en = 1'b0;
      do_step(1'b1);
      chk("pre_rst_req", 32'(fetch_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_req",   32'(fetch_req),  32'd0);
      chk("async_rst_pos",   32'(rot_pos),    32'd0);
      chk("async_rst_bus",   32'(rot_bus),    32'h400);
      chk("async_rst_data",  32'(disp_data),  32'd0);
      chk("async_rst_valid", 32'(disp_valid), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
